// File: rtl/ft_pkg.sv
// Shared types and constants for the lockstep recovery sequencer.
// Holds the FSM state encoding, the register-count derivation and the replay start address.
package ft_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HALT    = 3'd1,
        REPLAY  = 3'd2,
        RESTORE = 3'd3,
        RESUME  = 3'd4,
        FAIL    = 3'd5
    } rec_state_e;

    // x0 is hardwired to zero in the cores, so replay starts at x1.
    localparam int REPLAY_FIRST = 1;

    function automatic int nreg_f(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/recovery_sequencer_if.sv
// Bundle between the sequencer and comparator/sgpr/spc/core debug ports.
// master = sequencer side, slave = environment driving error/acks/shadow PC.
interface recovery_sequencer_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
);
    logic                  error_i;
    logic                  halted_a_i;
    logic                  halted_b_i;
    logic [DATA_WIDTH-1:0] spc_i;
    logic                  halt_o;
    logic                  resume_o;
    logic                  replay_we_o;
    logic [ADDR_WIDTH-1:0] replay_addr_o;
    logic                  pc_we_o;
    logic [DATA_WIDTH-1:0] pc_o;
    logic                  busy_o;
    logic                  fatal_o;
    logic [CNT_WIDTH-1:0]  err_count_o;

    modport master (
        input  error_i, halted_a_i, halted_b_i, spc_i,
        output halt_o, resume_o, replay_we_o, replay_addr_o, pc_we_o, pc_o,
               busy_o, fatal_o, err_count_o
    );

    modport slave (
        output error_i, halted_a_i, halted_b_i, spc_i,
        input  halt_o, resume_o, replay_we_o, replay_addr_o, pc_we_o, pc_o,
               busy_o, fatal_o, err_count_o
    );
endinterface

// File: rtl/halt_watchdog.sv
// Counts HALT cycles spent waiting for both core acks; expired_o flags the last allowed cycle.
// expired_o is combinational on the enable so the FSM leaves HALT exactly after HALT_TIMEOUT cycles.
module halt_watchdog #(
    parameter int HALT_TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam int WD_WIDTH = $clog2(HALT_TIMEOUT + 1);
    localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(HALT_TIMEOUT - 1);

    logic [WD_WIDTH-1:0] wd_q, wd_d;

    always_comb begin
        wd_d = wd_q;
        if (clear_i) begin
            wd_d = '0;
        end else if (enable_i && (wd_q != WD_LAST)) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign expired_o = enable_i && (wd_q == WD_LAST);

endmodule

// File: rtl/recovery_sequencer.sv
// Rollback FSM: halt both cores, wait acks (watchdog-bounded), replay x1..xN-1, restore PC, resume.
// Moore outputs only; FT_ERR_COUNT_EN builds the saturating recovery counter, otherwise err_count_o is 0.
module recovery_sequencer
    import ft_pkg::*;
#(
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int HALT_TIMEOUT = 16,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    recovery_sequencer_if.master bus
);
    localparam int NREG = nreg_f(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = ADDR_WIDTH'(REPLAY_FIRST);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = ADDR_WIDTH'(NREG - 1);

    rec_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  both_acked;
    logic                  wd_expired;
    logic [CNT_WIDTH-1:0]  err_count;

    assign both_acked = bus.halted_a_i && bus.halted_b_i;

    halt_watchdog #(
        .HALT_TIMEOUT (HALT_TIMEOUT)
    ) u_halt_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (state_q == IDLE),
        .enable_i  ((state_q == HALT) && !both_acked),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (bus.error_i) begin
                    state_d = HALT;
                    pc_d    = bus.spc_i;
                end
            end
            HALT: begin
                // A simultaneous final ack wins over watchdog expiry.
                if (both_acked) begin
                    state_d = REPLAY;
                    addr_d  = ADDR_FIRST;
                end else if (wd_expired) begin
                    state_d = FAIL;
                end
            end
            REPLAY: begin
                if (addr_q == ADDR_LAST) begin
                    state_d = RESTORE;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            RESTORE: state_d = RESUME;
            RESUME:  state_d = IDLE;
            FAIL:    state_d = FAIL;
            default: state_d = IDLE;
        endcase
    end

`ifdef FT_ERR_COUNT_EN
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if ((state_q == IDLE) && bus.error_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_count = cnt_q;
`else
    assign err_count = '0;
`endif

    always_comb begin
        bus.halt_o        = (state_q == HALT) || (state_q == REPLAY) ||
                            (state_q == RESTORE) || (state_q == FAIL);
        bus.resume_o      = (state_q == RESUME);
        bus.replay_we_o   = (state_q == REPLAY);
        bus.replay_addr_o = addr_q;
        bus.pc_we_o       = (state_q == RESTORE);
        bus.pc_o          = pc_q;
        bus.busy_o        = (state_q != IDLE);
        bus.fatal_o       = (state_q == FAIL);
        bus.err_count_o   = err_count;
    end

endmodule

// File: tb/tb_recovery_sequencer.sv
// Directed scenarios with an event scoreboard: stimulus queues expected replay/restore/resume strobes,
// a negedge monitor pops and compares them whenever the DUT raises one.
module tb_recovery_sequencer;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int HT = 16;
    localparam int CW = 2;
    localparam int NR = 32;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    recovery_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

    recovery_sequencer #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .HALT_TIMEOUT (HT),
        .CNT_WIDTH    (CW)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef enum int {EV_REPLAY = 0, EV_RESTORE = 1, EV_RESUME = 2} ev_e;
    typedef struct {
        ev_e         kind;
        int          addr;
        logic [31:0] pc;
        int          at;
    } ev_t;

    ev_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_count(input int n);
`ifdef FT_ERR_COUNT_EN
        int sat = (1 << CW) - 1;
        return (n > sat) ? sat : n;
`else
        return 0;
`endif
    endfunction

    // Expected strobes for a recovery whose error is sampled at edge k with d extra ack-wait cycles.
    task automatic push_recovery(input int k, input int d, input logic [31:0] pc,
                                 input int last_addr, input bit full);
        ev_t e;
        for (int a = 1; a <= last_addr; a++) begin
            e = '{kind: EV_REPLAY, addr: a, pc: pc, at: k + d + a};
            exp_q.push_back(e);
        end
        if (full) begin
            e = '{kind: EV_RESTORE, addr: 0, pc: pc, at: k + d + NR};
            exp_q.push_back(e);
            e = '{kind: EV_RESUME, addr: 0, pc: pc, at: k + d + NR + 1};
            exp_q.push_back(e);
        end
    endtask

    task automatic chk_idle(input string tag, input logic [31:0] pc, input int cnt);
        chk({tag, "_halt"},   bus.halt_o, 0);
        chk({tag, "_resume"}, bus.resume_o, 0);
        chk({tag, "_we"},     bus.replay_we_o, 0);
        chk({tag, "_addr"},   bus.replay_addr_o, 0);
        chk({tag, "_pc_we"},  bus.pc_we_o, 0);
        chk({tag, "_pc"},     bus.pc_o, pc);
        chk({tag, "_busy"},   bus.busy_o, 0);
        chk({tag, "_fatal"},  bus.fatal_o, 0);
        chk({tag, "_count"},  bus.err_count_o, cnt);
    endtask

    ev_e mon_kind;
    ev_t mon_ev;
    always @(negedge clk_i) begin
        if (bus.replay_we_o || bus.pc_we_o || bus.resume_o) begin
            mon_kind = bus.replay_we_o ? EV_REPLAY : (bus.pc_we_o ? EV_RESTORE : EV_RESUME);
            chk("strobe_onehot", int'(bus.replay_we_o) + int'(bus.pc_we_o) + int'(bus.resume_o), 1);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe_kind", int'(mon_kind), -1);
            end else begin
                mon_ev = exp_q.pop_front();
                chk("ev_kind", int'(mon_kind), int'(mon_ev.kind));
                chk("ev_cycle", cyc, mon_ev.at);
                chk("ev_busy", bus.busy_o, 1);
                case (mon_ev.kind)
                    EV_REPLAY: begin
                        chk("replay_addr", bus.replay_addr_o, mon_ev.addr);
                        chk("replay_halt", bus.halt_o, 1);
                    end
                    EV_RESTORE: begin
                        chk("restore_pc", bus.pc_o, mon_ev.pc);
                        chk("restore_halt", bus.halt_o, 1);
                    end
                    default: chk("resume_halt", bus.halt_o, 0);
                endcase
            end
        end
    end

    int k, k2, bad;

    initial begin
        bus.error_i    = 1'b0;
        bus.halted_a_i = 1'b0;
        bus.halted_b_i = 1'b0;
        bus.spc_i      = '0;
        repeat (3) @(negedge clk_i);
        chk_idle("reset", 32'h0, 0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Basic recovery, acks immediate, error pulses during replay ignored.
        k = cyc + 1;
        push_recovery(k, 0, 32'h0000_0200, NR - 1, 1'b1);
        bus.error_i = 1'b1; bus.spc_i = 32'h0000_0200;
        bus.halted_a_i = 1'b1; bus.halted_b_i = 1'b1;
        @(negedge clk_i);
        bus.error_i = 1'b0; bus.spc_i = 32'hdead_beef;
        chk("basic_halt_k1", bus.halt_o, 1);
        chk("basic_busy_k1", bus.busy_o, 1);
        chk("basic_count", bus.err_count_o, exp_count(1));
        repeat (5) @(negedge clk_i);
        bus.error_i = 1'b1;
        @(negedge clk_i);
        bus.error_i = 1'b0;
        repeat (28) @(negedge clk_i);
        chk("basic_busy_end", bus.busy_o, 0);
        chk("basic_halt_end", bus.halt_o, 0);
        chk("basic_pc_kept", bus.pc_o, 32'h0000_0200);
        chk("basic_drained", exp_q.size(), 0);

        // Ack delay: A at HALT cycle 2, B at HALT cycle 5; acks then drop during replay.
        bus.halted_a_i = 1'b0; bus.halted_b_i = 1'b0;
        k = cyc + 1;
        push_recovery(k, 4, 32'h1234_5678, NR - 1, 1'b1);
        bus.error_i = 1'b1; bus.spc_i = 32'h1234_5678;
        @(negedge clk_i);
        bus.error_i = 1'b0;
        chk("delay_count", bus.err_count_o, exp_count(2));
        @(negedge clk_i);
        bus.halted_a_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("delay_a_only_halt", bus.halt_o, 1);
        chk("delay_a_only_no_replay", bus.replay_we_o, 0);
        @(negedge clk_i);
        bus.halted_b_i = 1'b1;
        @(negedge clk_i);
        chk("delay_replay_start", bus.replay_we_o, 1);
        bus.halted_a_i = 1'b0; bus.halted_b_i = 1'b0;
        repeat (33) @(negedge clk_i);
        chk("delay_busy_end", bus.busy_o, 0);
        chk("delay_drained", exp_q.size(), 0);

        // error_i held high: back-to-back recoveries, second captures the new shadow PC.
        bus.halted_a_i = 1'b1; bus.halted_b_i = 1'b1;
        k  = cyc + 1;
        k2 = k + NR + 3;
        push_recovery(k, 0, 32'h0000_00a0, NR - 1, 1'b1);
        push_recovery(k2, 0, 32'h0000_00b0, NR - 1, 1'b1);
        bus.error_i = 1'b1; bus.spc_i = 32'h0000_00a0;
        @(negedge clk_i);
        bus.spc_i = 32'h0000_00b0;
        chk("held_count1", bus.err_count_o, exp_count(3));
        repeat (34) @(negedge clk_i);
        chk("held_idle_gap_busy", bus.busy_o, 0);
        chk("held_pc1", bus.pc_o, 32'h0000_00a0);
        @(negedge clk_i);
        chk("held_second_halt", bus.halt_o, 1);
        chk("held_count2", bus.err_count_o, exp_count(4));
        bus.error_i = 1'b0;
        repeat (34) @(negedge clk_i);
        chk("held_busy_end", bus.busy_o, 0);
        chk("held_pc2", bus.pc_o, 32'h0000_00b0);
        chk("held_drained", exp_q.size(), 0);

        // Reset while replay shows address 10.
        k = cyc + 1;
        push_recovery(k, 0, 32'h0000_0300, 10, 1'b0);
        bus.error_i = 1'b1; bus.spc_i = 32'h0000_0300;
        @(negedge clk_i);
        bus.error_i = 1'b0;
        chk("rstmid_count", bus.err_count_o, exp_count(5));
        repeat (10) @(negedge clk_i);
        chk("rstmid_addr10", bus.replay_addr_o, 10);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk_idle("rstmid", 32'h0, 0);
        chk("rstmid_drained", exp_q.size(), 0);

        // Timeout with only core A acking, then FAIL held until reset.
        bus.halted_a_i = 1'b1; bus.halted_b_i = 1'b0;
        bus.error_i = 1'b1; bus.spc_i = 32'h0000_0400;
        @(negedge clk_i);
        bus.error_i = 1'b0;
        chk("to_count", bus.err_count_o, exp_count(1));
        repeat (HT - 1) @(negedge clk_i);
        chk("to_last_halt_fatal", bus.fatal_o, 0);
        chk("to_last_halt_halt", bus.halt_o, 1);
        @(negedge clk_i);
        chk("to_fatal", bus.fatal_o, 1);
        chk("to_fail_halt", bus.halt_o, 1);
        chk("to_fail_busy", bus.busy_o, 1);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 20) bus.halted_b_i = 1'b1;
            if (i == 40) bus.error_i = 1'b1;
            if (i == 41) bus.error_i = 1'b0;
            @(negedge clk_i);
            if (!(bus.fatal_o && bus.halt_o && bus.busy_o) || bus.resume_o || bus.replay_we_o)
                bad++;
        end
        chk("to_fail_hold_bad_cycles", bad, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        chk_idle("to_reset", 32'h0, 0);
        chk("final_drained", exp_q.size(), 0);

        repeat (2) @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
